// File: rtl/mem_arb8x8_if.sv
// mem_arb8x8_if: requester handshake and memory-side bus of the two-port memory arbiter
interface mem_arb8x8_if;
  logic       req_a, req_b;
  logic       rw_a, rw_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b;
  logic [7:0] rdata;
  logic       busy;
  logic       mem_select;
  logic       mem_rw;
  logic [2:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  modport slave (
    input  req_a, req_b, rw_a, rw_b, addr_a, addr_b, wdata_a, wdata_b, mem_data_out,
    output ack_a, ack_b, rdata, busy, mem_select, mem_rw, mem_address, mem_data_in
  );
  modport master (
    output req_a, req_b, rw_a, rw_b, addr_a, addr_b, wdata_a, wdata_b, mem_data_out,
    input  ack_a, ack_b, rdata, busy, mem_select, mem_rw, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_arb8x8.sv
// mem_arb8x8: two-requester arbiter for an 8x8 memory; MEM_ARB_RR_EN selects round-robin ties, else A wins ties
module mem_arb8x8 #(
  parameter int HOLD_CYCLES = 1
) (
  input logic         clk,
  input logic         reset,
  mem_arb8x8_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       owner_b_q, owner_b_d;
  logic       lrw_q, lrw_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       mem_rw_q, mem_rw_d;
  logic       sel_q, sel_d;
  logic       ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic       busy_q, busy_d;
  logic       grant, pick_b, last_access;
  // next state: owner_b_q doubles as the last-grant pointer when round-robin is enabled
  always_comb begin
    grant       = state_q == IDLE && (bus.req_a || bus.req_b);
`ifdef MEM_ARB_RR_EN
    pick_b      = bus.req_b && (!bus.req_a || !owner_b_q);
`else
    pick_b      = bus.req_b && !bus.req_a;
`endif
    last_access = cnt_q == 2'(HOLD_CYCLES - 1);
    state_d     = state_q == IDLE   ? (grant ? SETUP : IDLE) :
                  state_q == SETUP  ? ACCESS :
                  state_q == ACCESS ? (last_access ? DONE : ACCESS) : IDLE;
    cnt_d       = state_q == ACCESS ? cnt_q + 2'd1 : 2'd0;
    owner_b_d   = grant ? pick_b : owner_b_q;
    lrw_d       = grant ? (pick_b ? bus.rw_b : bus.rw_a) : lrw_q;
    addr_d      = grant ? (pick_b ? bus.addr_b : bus.addr_a) : addr_q;
    wdata_d     = grant ? (pick_b ? bus.wdata_b : bus.wdata_a) : wdata_q;
    rdata_d     = (state_q == ACCESS && last_access && lrw_q) ? bus.mem_data_out : rdata_q;
    mem_rw_d    = state_d == IDLE ? 1'b1 : lrw_d;
    sel_d       = state_d == ACCESS;
    ack_a_d     = state_d == DONE && !owner_b_d;
    ack_b_d     = state_d == DONE && owner_b_d;
    busy_d      = state_d != IDLE;
  end
  // all state and outputs registered; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      owner_b_q <= 1'b1;
      lrw_q     <= 1'b1;
      addr_q    <= 3'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      mem_rw_q  <= 1'b1;
      sel_q     <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_b_q <= owner_b_d;
      lrw_q     <= lrw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mem_rw_q  <= mem_rw_d;
      sel_q     <= sel_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.ack_a       = ack_a_q;
  assign bus.ack_b       = ack_b_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.mem_select  = sel_q;
  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
endmodule
